// File: rtl/counter_pkg.sv
// Shared definitions for the counter sequencing controller and its datapath:
// state encoding, default widths and mode constants.
package counter_pkg;

    localparam int DEF_WIDTH  = 4;
    localparam int DEF_WRAP_W = 8;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/counter_core.sv
// Counter datapath: clearable, enable-gated up counter with a terminal-count
// compare against an externally held terminal value.
module counter_core
    import counter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] term,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    logic [WIDTH-1:0] count_r;

    // Count register: clear wins over enable, otherwise hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r <= {WIDTH{1'b0}};
        end else if (clr) begin
            count_r <= {WIDTH{1'b0}};
        end else if (en) begin
            count_r <= count_r + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
    assign tc    = (count_r == term);

endmodule

// File: rtl/counter_ctrl.sv
// Sequencing controller: command decode, terminal/mode latches, saturating
// wrap counter and status decode around a single counter_core instance.
module counter_ctrl
    import counter_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int WRAP_W = DEF_WRAP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              mode,
    input  logic [WIDTH-1:0]  term,
    output logic [WIDTH-1:0]  count,
    output logic              rco,
    output logic              busy,
    output logic              done,
    output logic [WRAP_W-1:0] wraps
);

    state_t              state_r;
    state_t              state_nx_s;
    logic [WIDTH-1:0]    term_q_r;
    logic                mode_q_r;
    logic [WRAP_W-1:0]   wraps_r;
    logic [WRAP_W-1:0]   wraps_nx_s;
    logic                clr_s;
    logic                en_s;
    logic                latch_s;
    logic                tc_s;

    counter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_s),
        .en    (en_s),
        .term  (term_q_r),
        .count (count),
        .tc    (tc_s)
    );

    // Next-state and datapath control; stop beats start, start beats pause.
    always_comb begin
        state_nx_s = state_r;
        clr_s      = 1'b0;
        en_s       = 1'b0;
        latch_s    = 1'b0;
        wraps_nx_s = wraps_r;
        if (stop) begin
            state_nx_s = S_IDLE;
            clr_s      = 1'b1;
        end else if (start && ((state_r == S_IDLE) || (state_r == S_DONE))) begin
            state_nx_s = S_RUN;
            clr_s      = 1'b1;
            latch_s    = 1'b1;
            wraps_nx_s = {WRAP_W{1'b0}};
        end else begin
            case (state_r)
                S_RUN: begin
                    if (pause) begin
                        // Pause defers both the increment and any terminal action.
                        state_nx_s = S_HOLD;
                    end else if (tc_s) begin
                        if (mode_q_r == MODE_PERIODIC) begin
                            clr_s = 1'b1;
                            if (wraps_r != {WRAP_W{1'b1}}) begin
                                wraps_nx_s = wraps_r + {{(WRAP_W-1){1'b0}}, 1'b1};
                            end else begin
                                wraps_nx_s = wraps_r;
                            end
                        end else begin
                            state_nx_s = S_DONE;
                        end
                    end else begin
                        en_s = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!pause) begin
                        state_nx_s = S_RUN;
                    end else begin
                        state_nx_s = S_HOLD;
                    end
                end
                S_IDLE: state_nx_s = S_IDLE;
                S_DONE: state_nx_s = S_DONE;
                default: begin
                    state_nx_s = S_IDLE;
                    clr_s      = 1'b1;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Terminal count and mode are captured only on an accepted start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            term_q_r <= {WIDTH{1'b0}};
            mode_q_r <= MODE_ONESHOT;
        end else if (latch_s) begin
            term_q_r <= term;
            mode_q_r <= mode;
        end else begin
            term_q_r <= term_q_r;
            mode_q_r <= mode_q_r;
        end
    end

    // Wrap-event counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wraps_r <= {WRAP_W{1'b0}};
        end else begin
            wraps_r <= wraps_nx_s;
        end
    end

    assign rco   = (state_r == S_RUN) && tc_s;
    assign busy  = (state_r == S_RUN) || (state_r == S_HOLD);
    assign done  = (state_r == S_DONE);
    assign wraps = wraps_r;

endmodule
